// File: rtl/argmax_classifier.sv
// argmax_classifier: consumes one frame of N_CLASSES float32 scores over a
// valid/ready stream, tracks the running maximum under IEEE-754 total order
// (with -0.0 below +0.0), then presents the winning index and its raw score.
// A single-cycle done pulse on the result handshake restarts the upstream frame.
//
// Optional feature: define ARGMAX_NAN_FILTER_EN to keep NaN scores from ever
// winning and to expose a per-frame sticky nan_seen flag.
module argmax_classifier #(
  parameter int N_CLASSES = 10,
  parameter int IDX_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [31:0]      din,
  input  logic             tvalid_in,
  output logic             tready_in,
  output logic [IDX_W-1:0] class_idx,
  output logic [31:0]      max_val,
  output logic             tvalid_out,
  input  logic             tready_out,
`ifdef ARGMAX_NAN_FILTER_EN
  output logic             nan_seen,
`endif
  output logic             done
);

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_OUTPUT  = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_CLASSES - 1);
  localparam logic [31:0]      QNAN_BITS = 32'h7FC0_0000;

  state_t           state;
  logic [IDX_W-1:0] count;
  logic [31:0]      best_val;
  logic [IDX_W-1:0] best_idx;

  logic [31:0]      next_val;
  logic [IDX_W-1:0] next_idx;
  logic             take;
  logic             first_beat;

`ifdef ARGMAX_NAN_FILTER_EN
  logic best_valid;
  logic nan_acc;
  logic din_nan;
  logic next_valid;
  logic next_nan;
`endif

  // Map float bits onto an unsigned key whose order matches numeric order:
  // negatives invert fully, positives just flip the sign bit above them.
  function automatic logic [31:0] order_key(input logic [31:0] v);
    return v[31] ? ~v : (v ^ 32'h8000_0000);
  endfunction

  // Input is accepted only while collecting, enabled and out of reset.
  assign tready_in = en && !rst && (state == S_COLLECT);

  // Candidate running best after the beat currently on din.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    first_beat = (count == '0);
    take       = 1'b0;
`ifdef ARGMAX_NAN_FILTER_EN
    din_nan    = (&din[30:23]) && (|din[22:0]);
    take       = !din_nan &&
                 (first_beat || !best_valid || (order_key(din) > order_key(best_val)));
    next_valid = take || (!first_beat && best_valid);
    next_nan   = din_nan || (!first_beat && nan_acc);
`else
    take       = first_beat || (order_key(din) > order_key(best_val));
`endif
    next_val   = take ? din   : best_val;
    next_idx   = take ? count : best_idx;
  end

  // Frame collection, result presentation and done pulse.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state      <= S_COLLECT;
      count      <= '0;
      best_val   <= '0;
      best_idx   <= '0;
      class_idx  <= '0;
      max_val    <= '0;
      tvalid_out <= 1'b0;
      done       <= 1'b0;
`ifdef ARGMAX_NAN_FILTER_EN
      best_valid <= 1'b0;
      nan_acc    <= 1'b0;
      nan_seen   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (en) begin
        case (state)
          S_COLLECT: begin
            if (tvalid_in) begin
              best_val <= next_val;
              best_idx <= next_idx;
              count    <= count + 1'b1;
`ifdef ARGMAX_NAN_FILTER_EN
              best_valid <= next_valid;
              nan_acc    <= next_nan;
`endif
              if (count == LAST_IDX) begin
                state      <= S_OUTPUT;
                tvalid_out <= 1'b1;
                class_idx  <= next_idx;
                max_val    <= next_val;
`ifdef ARGMAX_NAN_FILTER_EN
                nan_seen   <= next_nan;
                if (!next_valid) begin
                  class_idx <= '0;
                  max_val   <= QNAN_BITS;
                end
`endif
              end
            end
          end
          S_OUTPUT: begin
            if (tready_out) begin
              tvalid_out <= 1'b0;
              done       <= 1'b1;
              count      <= '0;
              state      <= S_COLLECT;
`ifdef ARGMAX_NAN_FILTER_EN
              nan_seen   <= 1'b0;
`endif
            end
          end
          default: state <= S_COLLECT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_argmax_classifier.sv
// Self-checking bench for argmax_classifier: table of frames with hand-derived
// winners, a scoreboard queue filled when a frame's last beat is accepted and
// drained on each result handshake, plus sequences for backpressure, reset and
// enable stalls. Build with ARGMAX_NAN_FILTER_EN to match a NaN-filtering DUT.
module tb_argmax_classifier;

  localparam int N     = 10;
  localparam int IDX_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [31:0]      din;
  logic             tvalid_in;
  logic             tready_in;
  logic [IDX_W-1:0] class_idx;
  logic [31:0]      max_val;
  logic             tvalid_out;
  logic             tready_out;
  logic             done;
`ifdef ARGMAX_NAN_FILTER_EN
  logic             nan_seen;
`endif

  argmax_classifier #(.N_CLASSES(N), .IDX_W(IDX_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .din        (din),
    .tvalid_in  (tvalid_in),
    .tready_in  (tready_in),
    .class_idx  (class_idx),
    .max_val    (max_val),
    .tvalid_out (tvalid_out),
    .tready_out (tready_out),
`ifdef ARGMAX_NAN_FILTER_EN
    .nan_seen   (nan_seen),
`endif
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0][31:0] s;
    logic [IDX_W-1:0]   idx;
    logic [31:0]        val;
    logic               nan;
  } vec_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [31:0]      val;
    logic             nan;
  } exp_t;

  localparam int NV = 8;
  vec_t vecs [NV];
  exp_t sb [$];

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_on   = 1'b0;
  bit prev_hs  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Frame of 'fill' with up to three (index, value) overrides; index -1 = unused.
  function automatic logic [N-1:0][31:0] mk(input logic [31:0] fill,
                                            input int i1, input logic [31:0] v1,
                                            input int i2, input logic [31:0] v2,
                                            input int i3, input logic [31:0] v3);
    logic [N-1:0][31:0] f;
    for (int i = 0; i < N; i++) begin
      f[i] = fill;
      if (i == i1) f[i] = v1;
      if (i == i2) f[i] = v2;
      if (i == i3) f[i] = v3;
    end
    return f;
  endfunction

  // Result monitor: samples on the falling edge, i.e. the values the next
  // rising edge will see.
  always @(negedge clk) begin
    bit   hs;
    exp_t e;
    if (mon_on) begin
      check("done_pulse", {31'd0, done}, {31'd0, prev_hs});
      if (done && en && !rst) check("tready_in_with_done", {31'd0, tready_in}, 32'd1);
      hs = en && !rst && tvalid_out && tready_out;
      if (hs) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          check("class_idx", {28'd0, class_idx}, {28'd0, e.idx});
          check("max_val", max_val, e.val);
`ifdef ARGMAX_NAN_FILTER_EN
          check("nan_seen", {31'd0, nan_seen}, {31'd0, e.nan});
`endif
        end
      end
      prev_hs = hs;
    end
  end

  // Drives nbeats of frame fi. Entered and left 1 time unit after a rising edge.
  task automatic send_frame(input int fi, input int nbeats, input bit gaps,
                            input int stall_at, input bit push);
    int budget;
    bit acc;
    exp_t e;
    for (int b = 0; b < nbeats; b++) begin
      if (gaps && (b % 2 == 1)) begin
        tvalid_in = 1'b0;
        din       = 32'hDEAD_BEEF;
        @(posedge clk); #1;
      end
      if (b == stall_at) begin
        en        = 1'b0;
        tvalid_in = 1'b1;
        din       = vecs[fi].s[b];
        repeat (3) begin
          @(negedge clk);
          check("stall_tready_in", {31'd0, tready_in}, 32'd0);
          @(posedge clk); #1;
        end
        en = 1'b1;
      end
      din       = vecs[fi].s[b];
      tvalid_in = 1'b1;
      acc       = 1'b0;
      budget    = 0;
      while (!acc && budget < 50) begin
        @(negedge clk);
        acc = tready_in;
        if (acc && push && b == N - 1) begin
          e.idx = vecs[fi].idx;
          e.val = vecs[fi].val;
          e.nan = vecs[fi].nan;
          sb.push_back(e);
        end
        @(posedge clk); #1;
        budget++;
      end
      if (!acc) check("accept_timeout", 32'd0, 32'd1);
    end
    tvalid_in = 1'b0;
    if (nbeats == N) begin
      @(negedge clk);
      check("latency_tvalid_out", {31'd0, tvalid_out}, 32'd1);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{s: mk(32'h3E80_0000, 0, 32'h3F00_0000, 1, 32'h3F40_0000, 2, 32'h3F80_0000),
                idx: 4'd2, val: 32'h3F80_0000, nan: 1'b0};
    vecs[1] = '{s: mk(32'h3F00_0000, -1, 0, -1, 0, -1, 0),
                idx: 4'd0, val: 32'h3F00_0000, nan: 1'b0};
    vecs[2] = '{s: mk(32'hBF80_0000, 7, 32'hBF00_0000, -1, 0, -1, 0),
                idx: 4'd7, val: 32'hBF00_0000, nan: 1'b0};
    vecs[3] = '{s: mk(32'hBF80_0000, 0, 32'h8000_0000, 5, 32'h0000_0000, -1, 0),
                idx: 4'd5, val: 32'h0000_0000, nan: 1'b0};
    vecs[4] = '{s: mk(32'h3F80_0000, 9, 32'h4000_0000, -1, 0, -1, 0),
                idx: 4'd9, val: 32'h4000_0000, nan: 1'b0};
    vecs[5] = '{s: mk(32'h0000_0000, 3, 32'h7F80_0000, 8, 32'h7F7F_FFFF, -1, 0),
                idx: 4'd3, val: 32'h7F80_0000, nan: 1'b0};
`ifdef ARGMAX_NAN_FILTER_EN
    vecs[6] = '{s: mk(32'h3F00_0000, 4, 32'h7FC0_0000, 6, 32'h3F80_0000, -1, 0),
                idx: 4'd6, val: 32'h3F80_0000, nan: 1'b1};
    vecs[7] = '{s: mk(32'h7FC0_0001, -1, 0, -1, 0, -1, 0),
                idx: 4'd0, val: 32'h7FC0_0000, nan: 1'b1};
`else
    vecs[6] = '{s: mk(32'h3F00_0000, 4, 32'h7FC0_0000, 6, 32'h3F80_0000, -1, 0),
                idx: 4'd4, val: 32'h7FC0_0000, nan: 1'b0};
    vecs[7] = '{s: mk(32'h7FC0_0001, -1, 0, -1, 0, -1, 0),
                idx: 4'd0, val: 32'h7FC0_0001, nan: 1'b0};
`endif

    rst        = 1'b1;
    en         = 1'b1;
    din        = '0;
    tvalid_in  = 1'b0;
    tready_out = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_tready_in", {31'd0, tready_in}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_class_idx", {28'd0, class_idx}, 32'd0);
    check("reset_max_val", max_val, 32'd0);
    check("reset_tvalid_out", {31'd0, tvalid_out}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_tready_in", {31'd0, tready_in}, 32'd1);
`ifdef ARGMAX_NAN_FILTER_EN
    check("reset_nan_seen", {31'd0, nan_seen}, 32'd0);
`endif
    prev_hs = 1'b0;
    mon_on  = 1'b1;
    @(posedge clk); #1;

    // Table frames back to back with the consumer always ready.
    tready_out = 1'b1;
    for (int f = 0; f < NV; f++) send_frame(f, N, 1'b0, -1, 1'b1);

    // Backpressure: 50% input gaps, consumer stalled for 5 clocks.
    tready_out = 1'b0;
    send_frame(4, N, 1'b1, -1, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("hold_tvalid_out", {31'd0, tvalid_out}, 32'd1);
      check("hold_class_idx", {28'd0, class_idx}, {28'd0, vecs[4].idx});
      check("hold_max_val", max_val, vecs[4].val);
      check("hold_tready_in", {31'd0, tready_in}, 32'd0);
    end
    @(posedge clk); #1;
    tready_out = 1'b1;
    send_frame(0, N, 1'b0, -1, 1'b1);

    // Reset after 4 beats discards the partial frame.
    send_frame(2, 4, 1'b0, -1, 1'b0);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("midrst_tready_in", {31'd0, tready_in}, 32'd0);
      check("midrst_tvalid_out", {31'd0, tvalid_out}, 32'd0);
      check("midrst_done", {31'd0, done}, 32'd0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    send_frame(3, N, 1'b0, -1, 1'b1);

    // Reset while a result is pending drops it without a done pulse.
    tready_out = 1'b0;
    send_frame(5, N, 1'b0, -1, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("outrst_tvalid_out", {31'd0, tvalid_out}, 32'd0);
    @(posedge clk); #1;
    tready_out = 1'b1;

    // Enable stall mid-frame with valid held high.
    send_frame(0, N, 1'b0, 5, 1'b1);
    send_frame(6, N, 1'b1, 2, 1'b1);

    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    mon_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
